// File: rtl/cr_tx_sched_pkg.sv
// Shared constants for the credit-engine TX scheduler: flow/sequence field
// widths, the "no result" flow ID, the descriptor layout and a clog2 helper.
package cr_tx_sched_pkg;

    localparam int FLOW_ID_W      = 8;
    localparam int FLOW_SEQ_NUM_W = 16;
    localparam int TX_CNT_W       = 8;

    localparam logic [FLOW_ID_W-1:0] FLOW_ID_NONE = '1;

    typedef struct packed {
        logic [FLOW_ID_W-1:0]      fid;
        logic [FLOW_SEQ_NUM_W-1:0] seq;
        logic [TX_CNT_W-1:0]       tx_id;
    } desc_t;

    localparam int DESC_W = $bits(desc_t);

    function automatic int clogb2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cr_desc_fifo.sv
// Descriptor store: one write port, one read port, power-of-two depth.
// Writes into a full FIFO are dropped and latch a sticky overflow flag.
module cr_desc_fifo
    import cr_tx_sched_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = clogb2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic [AW:0]   cnt_o,
    output logic          empty_o,
    output logic          ovf_o
);

    localparam int            CW       = AW + 1;
    localparam logic [AW:0]   FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q;
    logic          do_wr, do_rd;

    assign empty_o = (cnt_q == '0);
    assign do_wr   = wr_en_i && (cnt_q != FULL_CNT);
    assign do_rd   = rd_en_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !do_rd)      cnt_d = cnt_q + CW'(1);
        else if (!do_wr && do_rd) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
            if (wr_en_i && !do_wr) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Head is forced to zero when empty so stale entries never leak out.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign cnt_o     = cnt_q;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/cr_tx_sched.sv
// Credit-checked TX pop scheduler with programmable inter-pulse gap and a
// descriptor FIFO. Define CR_TX_SCHED_STATS_EN to add the stat_* counters.
module cr_tx_sched
    import cr_tx_sched_pkg::*;
#(
    parameter int DESC_DEPTH = 8,
    parameter int TX_LAT     = 2,
    parameter int GAP_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [GAP_W-1:0]          gap_cfg,
    output logic                      tx_val,
    input  logic [FLOW_ID_W-1:0]      next_seq_fid_in,
    input  logic [FLOW_SEQ_NUM_W-1:0] next_seq_in,
    input  logic [TX_CNT_W-1:0]       next_seq_tx_id_in,
    output logic                      desc_val,
    input  logic                      desc_rdy,
    output logic [FLOW_ID_W-1:0]      desc_fid,
    output logic [FLOW_SEQ_NUM_W-1:0] desc_seq,
    output logic [TX_CNT_W-1:0]       desc_tx_id,
    output logic                      busy,
    output logic                      ovf_err
`ifdef CR_TX_SCHED_STATS_EN
    ,
    output logic [31:0]               stat_sent,
    output logic [31:0]               stat_none,
    output logic [31:0]               stat_stall
`endif
);

    localparam int FCW = clogb2(DESC_DEPTH) + 1;
    localparam int PCW = clogb2(TX_LAT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP, ST_DRAIN} state_e;

    state_e             state_q, state_d;
    logic [TX_LAT-1:0]  sr_q, sr_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d, gap_lim_q, gap_lim_d;
    logic [PCW-1:0]     pend_cnt;
    logic [FCW-1:0]     fifo_cnt;
    logic               credit_ok, exit_vld, wr_en, pop, fifo_empty;
    desc_t              wr_desc, rd_desc;

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < TX_LAT; i++) pend_cnt = pend_cnt + PCW'(sr_q[i]);
    end

    // In-flight pulses hold their credit until the result has been consumed.
    assign credit_ok = (int'(fifo_cnt) + int'(pend_cnt)) < DESC_DEPTH;
    assign tx_val    = (state_q == ST_ISSUE) && enable && credit_ok;
    assign sr_d      = (sr_q << 1) | TX_LAT'(tx_val);
    assign exit_vld  = sr_q[TX_LAT-1];
    assign wr_en     = exit_vld && (next_seq_fid_in != FLOW_ID_NONE);

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        gap_lim_d = gap_lim_q;
        if (tx_val) gap_cnt_d = '0;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end else if (tx_val && gap_cfg != '0) begin
                    state_d   = ST_GAP;
                    gap_lim_d = gap_cfg;
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end else begin
                    if (gap_cnt_q != '1) gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    if (gap_cnt_d >= gap_lim_q) state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: if (pend_cnt == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            gap_cnt_q <= '0;
            gap_lim_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            gap_cnt_q <= gap_cnt_d;
            gap_lim_q <= gap_lim_d;
        end
    end

    assign wr_desc.fid   = next_seq_fid_in;
    assign wr_desc.seq   = next_seq_in;
    assign wr_desc.tx_id = next_seq_tx_id_in;

    cr_desc_fifo #(.W(DESC_W), .DEPTH(DESC_DEPTH)) u_fifo (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_desc),
        .rd_en_i   (pop),
        .rd_data_o (rd_desc),
        .cnt_o     (fifo_cnt),
        .empty_o   (fifo_empty),
        .ovf_o     (ovf_err)
    );

    assign desc_val   = !fifo_empty;
    assign pop        = desc_val && desc_rdy;
    assign desc_fid   = rd_desc.fid;
    assign desc_seq   = rd_desc.seq;
    assign desc_tx_id = rd_desc.tx_id;
    assign busy       = (pend_cnt != '0) || (fifo_cnt != '0);

`ifdef CR_TX_SCHED_STATS_EN
    logic [31:0] stat_sent_q, stat_none_q, stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sent_q  <= '0;
            stat_none_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (pop)                   stat_sent_q  <= stat_sent_q + 32'd1;
            if (exit_vld && !wr_en)    stat_none_q  <= stat_none_q + 32'd1;
            if (state_q == ST_ISSUE && enable && !credit_ok)
                                       stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_sent  = stat_sent_q;
    assign stat_none  = stat_none_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_cr_tx_sched.sv
// Randomized bench for cr_tx_sched against a queue-based reference model.
module tb_cr_tx_sched;
    import cr_tx_sched_pkg::*;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;

    logic                      clk, rst_n, enable, desc_rdy;
    logic [7:0]                gap_cfg;
    logic                      tx_val, desc_val, busy, ovf_err;
    logic [FLOW_ID_W-1:0]      next_seq_fid_in, desc_fid;
    logic [FLOW_SEQ_NUM_W-1:0] next_seq_in, desc_seq;
    logic [TX_CNT_W-1:0]       next_seq_tx_id_in, desc_tx_id;
`ifdef CR_TX_SCHED_STATS_EN
    logic [31:0]               stat_sent, stat_none, stat_stall;
`endif

    cr_tx_sched #(.DESC_DEPTH(DEPTH), .TX_LAT(LAT), .GAP_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .gap_cfg           (gap_cfg),
        .tx_val            (tx_val),
        .next_seq_fid_in   (next_seq_fid_in),
        .next_seq_in       (next_seq_in),
        .next_seq_tx_id_in (next_seq_tx_id_in),
        .desc_val          (desc_val),
        .desc_rdy          (desc_rdy),
        .desc_fid          (desc_fid),
        .desc_seq          (desc_seq),
        .desc_tx_id        (desc_tx_id),
        .busy              (busy),
        .ovf_err           (ovf_err)
`ifdef CR_TX_SCHED_STATS_EN
        ,
        .stat_sent         (stat_sent),
        .stat_none         (stat_none),
        .stat_stall        (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec, n_err, cyc;
    int en_p, rdy_p, none_p, gap_fix;
    bit chk_gap;

    // Reference model: session phase (0 idle, 1 issuing, 2 draining),
    // earliest cycle a pulse may occur, in-flight pulse times, FIFO contents.
    int    mphase, next_ok;
    int    infl[$];
    desc_t mq[$];
    bit    movf;
    int    msent, mnone, mstall;

    int pulses, first_tx, first_dv, dsent, dv_seen, last_pulse, rel;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        infl.delete();
        mphase = 0;
        next_ok = 0;
        movf = 1'b0;
        msent = 0;
        mnone = 0;
        mstall = 0;
    endtask

    task automatic clr_rec();
        pulses = 0; first_tx = -1; first_dv = -1; dsent = 0; dv_seen = 0; last_pulse = -1;
    endtask

    task automatic step();
        desc_t hd, nd;
        bit    etx, edv, credit, wr, full;
        int    pend;
        @(posedge clk); #1;
        enable            = ($urandom_range(99) < en_p);
        desc_rdy          = ($urandom_range(99) < rdy_p);
        gap_cfg           = (gap_fix >= 0) ? 8'(gap_fix) : 8'($urandom_range(4));
        next_seq_fid_in   = ($urandom_range(99) < none_p) ? FLOW_ID_NONE : 8'($urandom_range(254));
        next_seq_in       = 16'($urandom);
        next_seq_tx_id_in = 8'($urandom);
        @(negedge clk);
        pend   = infl.size();
        credit = (mq.size() + pend) < DEPTH;
        etx    = (mphase == 1) && enable && (cyc >= next_ok) && credit;
        edv    = (mq.size() != 0);
        hd     = edv ? mq[0] : '0;
        chk("tx_val", tx_val, etx);
        chk("desc_val", desc_val, edv);
        chk("desc", {desc_fid, desc_seq, desc_tx_id}, hd);
        chk("busy", busy, edv || pend != 0);
        chk("ovf_err", ovf_err, movf);
        if (tx_val) begin
            pulses++;
            if (first_tx < 0) first_tx = cyc;
            if (chk_gap && last_pulse >= 0) chk("gap_space", cyc - last_pulse, gap_fix + 1);
            last_pulse = cyc;
        end
        if (desc_val) begin
            dv_seen++;
            if (first_dv < 0) first_dv = cyc;
            if (desc_rdy) dsent++;
        end
        if (mphase == 1 && enable && cyc >= next_ok && !credit) mstall++;
        case (mphase)
            0: if (enable) begin mphase = 1; next_ok = cyc + 1; end
            1: if (!enable) mphase = 2;
               else if (etx) next_ok = cyc + int'(gap_cfg) + 1;
            default: if (pend == 0) mphase = 0;
        endcase
        full = (mq.size() >= DEPTH);
        wr   = 1'b0;
        if (pend != 0 && infl[0] == cyc - LAT) begin
            void'(infl.pop_front());
            if (next_seq_fid_in != FLOW_ID_NONE) wr = 1'b1;
            else mnone++;
        end
        if (edv && desc_rdy) begin void'(mq.pop_front()); msent++; end
        if (wr) begin
            if (full) movf = 1'b1;
            else begin
                nd.fid = next_seq_fid_in; nd.seq = next_seq_in; nd.tx_id = next_seq_tx_id_in;
                mq.push_back(nd);
            end
        end
        if (etx) infl.push_back(cyc);
        cyc++;
    endtask

    task automatic drain();
        int n;
        en_p = 0; rdy_p = 100; n = 0;
        while (!(mphase == 0 && mq.size() == 0 && infl.size() == 0) && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", n < 100, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; chk_gap = 1'b0;
        rst_n = 1'b1; enable = 1'b0; desc_rdy = 1'b0; gap_cfg = '0;
        next_seq_fid_in = '0; next_seq_in = '0; next_seq_tx_id_in = '0;
        model_reset(); clr_rec();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_val", tx_val, 0);
        chk("rst_desc_val", desc_val, 0);
        chk("rst_desc", {desc_fid, desc_seq, desc_tx_id}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf_err, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Back-to-back issue with all results valid.
        clr_rec(); en_p = 100; rdy_p = 100; none_p = 0; gap_fix = 0;
        repeat (30) step();
        chk("a_pulses", pulses, 29);
        chk("a_first_desc_lat", first_dv - first_tx, LAT + 1);

        // Stalled downstream: credits cap issue at DEPTH.
        drain(); clr_rec(); en_p = 100; rdy_p = 0;
        repeat (30) step();
        chk("b_pulses", pulses, DEPTH);
        chk("b_ovf", ovf_err, 0);

        // Fixed gap of 3 idle cycles.
        drain(); clr_rec(); en_p = 100; rdy_p = 100; gap_fix = 3; chk_gap = 1'b1;
        repeat (40) step();
        chk_gap = 1'b0;
        chk("c_pulses", pulses, 10);

        // Every result is FLOW_ID_NONE.
        drain(); clr_rec(); en_p = 100; rdy_p = 100; gap_fix = 0; none_p = 100;
        repeat (40) step();
        chk("d_desc_seen", dv_seen, 0);
        chk("d_pulses", pulses, 39);
        none_p = 0;

        // enable drops with two results in flight.
        drain(); clr_rec(); en_p = 100; rdy_p = 0;
        repeat (3) step();
        chk("e_pulses", pulses, 2);
        en_p = 0;
        repeat (6) step();
        chk("e_held", dsent, 0);
        rdy_p = 100;
        repeat (6) step();
        chk("e_sent", dsent, 2);
        chk("e_busy", busy, 0);

        // Random traffic.
        en_p = 92; rdy_p = 60; none_p = 25; gap_fix = -1;
        repeat (1500) step();
        rdy_p = 20;
        repeat (500) step();

        // Asynchronous reset mid-stream with five descriptors queued.
        drain(); clr_rec(); en_p = 100; rdy_p = 0; none_p = 0; gap_fix = 0;
        for (int i = 0; i < 40 && mq.size() != 5; i++) step();
        chk("f_fill5", mq.size(), 5);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("f_rst_tx_val", tx_val, 0);
        chk("f_rst_desc_val", desc_val, 0);
        chk("f_rst_desc", {desc_fid, desc_seq, desc_tx_id}, 0);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_ovf", ovf_err, 0);
        model_reset(); enable = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        clr_rec(); rel = cyc; en_p = 100; rdy_p = 100;
        repeat (20) step();
        chk("f_first_tx", first_tx - rel, 1);
        chk("f_pulses", pulses, 19);

        en_p = 85; rdy_p = 50; none_p = 30; gap_fix = -1;
        repeat (300) step();
`ifdef CR_TX_SCHED_STATS_EN
        chk("stat_sent", stat_sent, msent);
        chk("stat_none", stat_none, mnone);
        chk("stat_stall", stat_stall, mstall);
`endif
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
